// File: rtl/zorro_pkg.sv
// rtl/zorro_pkg.sv - shared types and constants for the Zorro III slave responder
package zorro_pkg;

  // Responder cycle phases
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAITDS,
    ST_SCSI,
    ST_ROM,
    ST_ACK,
    ST_ERR,
    ST_DONE
  } zorro_state_e;

  // Value of latched A23 selecting the target region
  localparam logic REGION_SCSI = 1'b1;
  localparam logic REGION_ROM  = 1'b0;

  // Default timing parameters
  localparam int DEFAULT_ROM_WAIT = 4;
  localparam int DEFAULT_TIMEOUT  = 255;

  // Width of the shared wait/timeout counter
  localparam int TIMER_W = 8;

endpackage

// File: rtl/zorro_slave_timer.sv
// rtl/zorro_slave_timer.sv - loadable saturating up/down counter with done flag
module zorro_slave_timer
  import zorro_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] limit,
  output logic         done
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] count;

  // Count register: load wins over counting; saturates at both ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) begin
        if (count != MAX) count <= count + ONE;
      end else begin
        if (count != '0) count <= count - ONE;
      end
    end
  end

  // Done means the coming counting edge lands on the terminal value:
  // up mode reaches limit, down mode runs out of loaded cycles
  always_comb begin
    if (up) begin
      done = ({1'b0, count} + {1'b0, ONE}) >= {1'b0, limit};
    end else begin
      done = (count <= ONE);
    end
  end

endmodule

// File: rtl/zorro_slave_responder.sv
// rtl/zorro_slave_responder.sv - Zorro III slave cycle responder for SCSI chip and boot ROM
module zorro_slave_responder
  import zorro_pkg::*;
#(
  parameter int ROM_WAIT = DEFAULT_ROM_WAIT,
  parameter int TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       ZORRO_FCS_n,
  input  logic [3:0] ZORRO_DS_n,
  input  logic       ZORRO_READ,
  input  logic [7:0] ZORRO_A,
  input  logic       ZORRO_A23,
  input  logic [7:0] CFG_BASE,
  input  logic       CONFIGURED,
  input  logic       BMASTER,
  input  logic       SCSI_SLACK_n,
  output logic       SLAVE_n,
  output logic       DTACK_n,
  output logic       BERR_n,
  output logic       SLV_DOE,
  output logic       SCSI_CS_n,
  output logic       SCSI_AS_n,
  output logic       ROM_OE_n
);

  localparam logic [TIMER_W-1:0] ROM_WAIT_V = TIMER_W'(ROM_WAIT);
  localparam logic [TIMER_W-1:0] TIMEOUT_V  = TIMER_W'(TIMEOUT);

  zorro_state_e state;

  logic [7:0] lat_a;
  logic       lat_region;
  logic       lat_read;

  logic               ds_any;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_en;
  logic               tmr_up;
  logic               tmr_done;

  assign ds_any = ~&ZORRO_DS_n;

  // Timer control: zeroed before WAITDS, counts up through WAITDS/SCSI,
  // reloaded with ROM_WAIT on ROM entry and counted down there
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    tmr_up   = 1'b1;
    case (state)
      ST_IDLE, ST_DECODE: begin
        tmr_load = 1'b1;
      end
      ST_WAITDS: begin
        if (ds_any && lat_region == REGION_ROM) begin
          tmr_load = 1'b1;
          tmr_val  = ROM_WAIT_V;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SCSI: begin
        tmr_en = 1'b1;
      end
      ST_ROM: begin
        tmr_en = 1'b1;
        tmr_up = 1'b0;
      end
      default: begin
      end
    endcase
  end

  zorro_slave_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RESET_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .up       (tmr_up),
    .limit    (TIMEOUT_V),
    .done     (tmr_done)
  );

  // Cycle FSM with registered bus outputs; FCS_n high ends any cycle first
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state      <= ST_IDLE;
      lat_a      <= '0;
      lat_region <= 1'b0;
      lat_read   <= 1'b0;
      SLAVE_n    <= 1'b1;
      DTACK_n    <= 1'b1;
      BERR_n     <= 1'b1;
      SLV_DOE    <= 1'b0;
      SCSI_CS_n  <= 1'b1;
      SCSI_AS_n  <= 1'b1;
      ROM_OE_n   <= 1'b1;
    end else if (state != ST_IDLE && ZORRO_FCS_n) begin
      state     <= ST_IDLE;
      SLAVE_n   <= 1'b1;
      DTACK_n   <= 1'b1;
      BERR_n    <= 1'b1;
      SLV_DOE   <= 1'b0;
      SCSI_CS_n <= 1'b1;
      SCSI_AS_n <= 1'b1;
      ROM_OE_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!ZORRO_FCS_n) begin
            lat_a      <= ZORRO_A;
            lat_region <= ZORRO_A23;
            lat_read   <= ZORRO_READ;
            state      <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // Bus-master ownership only matters here; later changes are ignored
          if (lat_a == CFG_BASE && CONFIGURED && !BMASTER) begin
            state   <= ST_WAITDS;
            SLAVE_n <= 1'b0;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_WAITDS: begin
          if (ds_any) begin
            SLV_DOE <= lat_read;
            if (lat_region == REGION_SCSI) begin
              state     <= ST_SCSI;
              SCSI_CS_n <= 1'b0;
              SCSI_AS_n <= 1'b0;
            end else begin
              state    <= ST_ROM;
              ROM_OE_n <= ~lat_read;
            end
          end else if (tmr_done) begin
            state  <= ST_ERR;
            BERR_n <= 1'b0;
          end
        end
        ST_SCSI: begin
          if (!SCSI_SLACK_n) begin
            state   <= ST_ACK;
            DTACK_n <= 1'b0;
          end else if (tmr_done) begin
            state     <= ST_ERR;
            BERR_n    <= 1'b0;
            SLV_DOE   <= 1'b0;
            SCSI_CS_n <= 1'b1;
            SCSI_AS_n <= 1'b1;
          end
        end
        ST_ROM: begin
          // Writes are acknowledged after the same wait; the data is dropped
          if (tmr_done) begin
            state   <= ST_ACK;
            DTACK_n <= 1'b0;
          end
        end
        default: begin
          // ACK, ERR and DONE hold until FCS_n rises
        end
      endcase
    end
  end

endmodule

// File: doc/zorro_slave_responder.md
ZORRO_SLAVE_RESPONDER -- requirements
Module: zorro_slave_responder

Interface
REQ-001 Parameter ROM_WAIT, default 4, ROM access wait cycles before DTACK (range 1..15).
REQ-002 Parameter TIMEOUT, default 255, cycles in WAITDS/SCSI before bus error (range 2..255).
REQ-003 CLK  in  1  25 MHz board clock; single clock domain.
REQ-004 RESET_n  in  1  asynchronous, active-low reset.
REQ-005 ZORRO_FCS_n  in  1  Zorro III full cycle strobe from bus.
REQ-006 ZORRO_DS_n  in  4  Zorro III data strobes, active low.
REQ-007 ZORRO_READ  in  1  1 = host read, 0 = host write.
REQ-008 ZORRO_A  in  8  address bits 31:24; compared against CFG_BASE.
REQ-009 ZORRO_A23  in  1  region select: 1 = SCSI chip, 0 = boot ROM.
REQ-010 CFG_BASE  in  8  autoconfig-assigned base, address bits 31:24.
REQ-011 CONFIGURED  in  1  autoconfig complete; no response while 0.
REQ-012 BMASTER  in  1  board owns bus as DMA master; no slave response while 1.
REQ-013 SCSI_SLACK_n  in  1  slave acknowledge from SCSI chip.
REQ-014 SLAVE_n  out  1  slave-selected indication to bus.
REQ-015 DTACK_n  out  1  cycle acknowledge to bus.
REQ-016 BERR_n  out  1  bus error on timeout.
REQ-017 SLV_DOE  out  1  drive board data onto bus (reads only).
REQ-018 SCSI_CS_n  out  1  SCSI chip select.
REQ-019 SCSI_AS_n  out  1  SCSI chip address strobe.
REQ-020 ROM_OE_n  out  1  boot ROM output enable.

Function
REQ-021 FSM states IDLE, DECODE, WAITDS, SCSI, ROM, ACK, ERR, DONE; every transition on rising CLK.
REQ-022 IDLE: ZORRO_FCS_n sampled low -> latch ZORRO_A, ZORRO_A23, ZORRO_READ on that edge; go DECODE.
REQ-023 DECODE: latched A == CFG_BASE and CONFIGURED and !BMASTER -> WAITDS with SLAVE_n low; else -> DONE, all outputs inactive.
REQ-024 WAITDS: any ZORRO_DS_n low -> SCSI if region = 1, ROM if region = 0.
REQ-025 SCSI: SCSI_CS_n and SCSI_AS_n low; SCSI_SLACK_n sampled low -> ACK.
REQ-026 ROM: ROM_OE_n low only if latched READ = 1; after exactly ROM_WAIT cycles in ROM -> ACK (writes acked, data discarded).
REQ-027 ACK: DTACK_n low; SCSI_CS_n/SCSI_AS_n/ROM_OE_n remain asserted as in preceding state; hold until ZORRO_FCS_n high.
REQ-028 Timeout counter: 8 bits, cleared on entry to WAITDS, increments each cycle in WAITDS and SCSI, saturates; reaching TIMEOUT -> ERR.
REQ-029 ERR: BERR_n low, SLAVE_n low, SCSI strobes released; hold until ZORRO_FCS_n high.
REQ-030 SLV_DOE = 1 only when latched READ = 1 and state is SCSI, ROM or ACK.
REQ-031 ZORRO_FCS_n sampled high in any non-IDLE state -> IDLE next edge; all outputs inactive in IDLE; this overrides simultaneous SLACK, ROM_WAIT expiry or timeout.
REQ-032 DONE: no outputs asserted; return to IDLE when ZORRO_FCS_n high.
REQ-033 BMASTER rising mid-cycle does not abort an accepted slave cycle; it is checked only in DECODE.
REQ-034 All outputs registered; response latency FCS low -> SLAVE_n low = 2 edges.

Reset
REQ-035 RESET_n low: state IDLE, counter 0, latches 0; SLAVE_n, DTACK_n, BERR_n, SCSI_CS_n, SCSI_AS_n, ROM_OE_n = 1; SLV_DOE = 0.
REQ-036 Reset mid-cycle releases all bus outputs immediately (asynchronous); after release, FSM waits in IDLE for next sampled FCS low.

Structure
REQ-037 Shared package zorro_pkg holds state encoding enum, region constants (REGION_SCSI = 1, REGION_ROM = 0) and default ROM_WAIT/TIMEOUT values.
REQ-038 One sub-module natural: zorro_slave_timer (loadable down/up counter with done flag) shared by ROM wait and timeout.

Verification
REQ-039 Base 0x40, CONFIGURED=1, read A=0x40 A23=1, DS_n=0000, SLACK low 3 cycles after CS -> SLAVE_n low edge 2, DTACK_n low 1 edge after SLACK sampled, SLV_DOE=1, all released edge after FCS high.
REQ-040 ROM read A23=0, ROM_WAIT=4 -> ROM_OE_n low, DTACK_n low exactly 4 cycles after ROM entry; ROM write -> ROM_OE_n stays 1, DTACK_n still after 4.
REQ-041 A=0x41 vs base 0x40, or CONFIGURED=0, or BMASTER=1 -> SLAVE_n, DTACK_n never asserted; FSM back to IDLE after FCS high.
REQ-042 SCSI access, SLACK held high, TIMEOUT=255 -> BERR_n low 255 cycles after WAITDS entry, DTACK_n stays 1.
REQ-043 FCS_n high same edge SLACK low -> IDLE, DTACK_n never asserted; RESET_n low in SCSI state -> all outputs inactive without clock edge.
